// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, bus bit constants and
// the open-drain drive helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic BIT_ACK     = 1'b0;
    localparam logic BIT_NACK    = 1'b1;
    localparam logic BIT_RW_READ = 1'b1;

    // Open-drain: putting a 0 on the bus means enabling the pull-down.
    function automatic logic drive_bit(input logic b);
        return ~b;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with registered edge detect and START/STOP decode.
// Events appear SYNC_STAGES + 1 cycles after the pad edge.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            sda_level <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_pad};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_pad};
            scl_prev  <= scl_s;
            sda_prev  <= sda_s;
            sda_level <= sda_s;
            scl_rise  <= scl_s & ~scl_prev;
            scl_fall  <= ~scl_s & scl_prev;
            // SCL must be high on both sides of the SDA edge to be a bus condition.
            start_det <= scl_s & scl_prev & ~sda_s & sda_prev;
            stop_det  <= scl_s & scl_prev & sda_s & ~sda_prev;
        end
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with byte register file and auto-incrementing pointer.
// Define I2C_TGT_STRETCH_EN to hold SCL low after each written byte until i_wr_ready.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        REG_AW      = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_sda_oe,
    output logic              o_scl_oe,
    input  logic [REG_AW-1:0] i_host_addr,
    output logic [7:0]        o_host_data,
    output logic              o_wr_en,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    input  logic              i_wr_ready,
    output logic              o_busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (i_clk),
        .rst       (i_rst),
        .scl_pad   (i_scl),
        .sda_pad   (i_sda),
        .sda_level (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [REG_AW-1:0]   ptr_q, ptr_d, ptr_next;
    logic                sda_oe_q, sda_oe_d;
    logic                scl_oe_q, scl_oe_d;
    logic                busy_q, busy_d;
    logic                wr_d;
    logic [7:0]          byte_in;
    logic [7:0]          regs [NUM_REGS];

    assign byte_in  = {shift_q[6:0], sda_s};
    assign ptr_next = (ptr_q == REG_AW'(NUM_REGS - 1)) ? '0 : ptr_q + REG_AW'(1);

`ifndef I2C_TGT_STRETCH_EN
    logic unused_wr_ready;
    assign unused_wr_ready = i_wr_ready;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        scl_oe_d  = scl_oe_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
        end else begin
`ifdef I2C_TGT_STRETCH_EN
            if (scl_oe_q && i_wr_ready) scl_oe_d = 1'b0;
`endif
            unique case (state_q)
                ST_IDLE, ST_WAIT_STOP: ;
                ST_DEV_ADDR, ST_PTR: begin
                    if (scl_rise && !bit_cnt_q[3]) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == ST_DEV_ADDR && shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ST_DEV_ACK;
                            sda_oe_d = drive_bit(BIT_ACK);
                            busy_d   = 1'b1;
                        end else if (state_q == ST_PTR && int'(shift_q) < NUM_REGS) begin
                            state_d  = ST_PTR_ACK;
                            ptr_d    = shift_q[REG_AW-1:0];
                            sda_oe_d = drive_bit(BIT_ACK);
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (shift_q[0] == BIT_RW_READ) begin
                            state_d  = ST_RD_DATA;
                            shift_d  = regs[ptr_q];
                            sda_oe_d = drive_bit(regs[ptr_q][7]);
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WR_DATA;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && !bit_cnt_q[3]) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            wr_d  = 1'b1;
                            ptr_d = ptr_next;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = ST_WR_ACK;
                        sda_oe_d = drive_bit(BIT_ACK);
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WR_DATA;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
`ifdef I2C_TGT_STRETCH_EN
                        scl_oe_d  = 1'b1;
`endif
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise && !bit_cnt_q[3]) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = ST_RD_ACK;
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_next;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = drive_bit(shift_q[6]);
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_s == BIT_NACK) begin
                        state_d = ST_WAIT_STOP;
                        busy_d  = 1'b0;
                    end else if (scl_fall) begin
                        state_d   = ST_RD_DATA;
                        bit_cnt_d = '0;
                        shift_d   = regs[ptr_q];
                        sda_oe_d  = drive_bit(regs[ptr_q][7]);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            scl_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            scl_oe_q  <= scl_oe_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_host_data <= '0;
        end else begin
            if (wr_d) begin
                regs[ptr_q] <= byte_in;
                o_wr_addr   <= ptr_q;
                o_wr_data   <= byte_in;
            end
            o_wr_en     <= wr_d;
            o_host_data <= regs[i_host_addr];
        end
    end

    assign o_sda_oe = sda_oe_q;
    assign o_scl_oe = scl_oe_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: an open-drain bus master drives SCL/SDA
// and each test task checks acks, read data, write strobes and host reads.
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] host_addr = '0;
    logic       wr_ready = 1'b1;
    logic       scl_line, sda_line;
    logic       sda_oe, scl_oe, wr_en, busy;
    logic [7:0] host_data, wr_data;
    logic [3:0] wr_addr;

    assign scl_line = m_scl & ~scl_oe;
    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regfile dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl_line),
        .i_sda       (sda_line),
        .o_sda_oe    (sda_oe),
        .o_scl_oe    (scl_oe),
        .i_host_addr (host_addr),
        .o_host_data (host_data),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_wr_ready  (wr_ready),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          stretch_held = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic        sda_ever = 1'b0;
    logic        busy_ever = 1'b0;
    logic        scl_oe_ever = 1'b0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
        if (sda_oe === 1'b1) sda_ever = 1'b1;
        if (busy === 1'b1) busy_ever = 1'b1;
        if (scl_oe === 1'b1) scl_oe_ever = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        int k = 0;
        m_scl = 1'b1;
        @(negedge clk);
        while (scl_line !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (scl_line !== 1'b1) begin
            checks++; errors++;
            $display("FAIL scl_release got %b exp 1", scl_line);
        end
    endtask

    task automatic send_bit(input logic b, output logic seen);
        m_sda = b;
        tick(H);
        scl_high();
        tick(H);
        seen = sda_line;
        m_scl = 1'b0;
        tick(3);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(~give_ack, s);
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        tick(H);
        scl_high();
        tick(H);
        m_sda = 1'b0;
        tick(H);
        m_scl = 1'b0;
        tick(3);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        tick(H);
        scl_high();
        tick(H);
        m_sda = 1'b1;
        tick(H);
    endtask

    task automatic check_writes(input string name);
        logic [11:0] e, g;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got %0d exp %0d", name, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s_strobe got %h exp %h", name, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        checks++;
        if ({sda_oe, scl_oe, wr_en, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000", {sda_oe, scl_oe, wr_en, busy});
        end
        checks++;
        if ({wr_addr, wr_data, host_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000", {wr_addr, wr_data, host_data});
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_write();
        logic [3:0] a;
        got_q.delete();
        exp_q.push_back({4'd3, 8'hA5});
        exp_q.push_back({4'd4, 8'h5A});
        bus_start();
        write_byte(8'h84, a[3]);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy got %b exp 1", busy);
        end
        write_byte(8'h03, a[2]);
        write_byte(8'hA5, a[1]);
        write_byte(8'h5A, a[0]);
        bus_stop();
        checks++;
        if (a !== 4'b1111) begin
            errors++;
            $display("FAIL write_acks got %b exp 1111", a);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_stop got %b exp 0", busy);
        end
        check_writes("write");
        host_addr = 4'd4;
        tick(2);
        checks++;
        if (host_data !== 8'h5A) begin
            errors++;
            $display("FAIL write_host got %h exp 5a", host_data);
        end
    endtask

    task automatic test_read_wrap();
        logic [4:0] a;
        logic [2:0] b;
        logic [7:0] d0, d1;
        exp_q.push_back({4'd15, 8'h3C});
        exp_q.push_back({4'd0, 8'hC3});
        exp_q.push_back({4'd1, 8'h99});
        bus_start();
        write_byte(8'h84, a[4]);
        write_byte(8'h0F, a[3]);
        write_byte(8'h3C, a[2]);
        write_byte(8'hC3, a[1]);
        write_byte(8'h99, a[0]);
        bus_stop();
        checks++;
        if (a !== 5'b11111) begin
            errors++;
            $display("FAIL wrap_write_acks got %b exp 11111", a);
        end
        check_writes("wrap_write");
        bus_start();
        write_byte(8'h84, b[2]);
        write_byte(8'h0F, b[1]);
        bus_start();
        write_byte(8'h85, b[0]);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_busy_nack got %b exp 0", busy);
        end
        bus_stop();
        checks++;
        if (b !== 3'b111) begin
            errors++;
            $display("FAIL read_acks got %b exp 111", b);
        end
        checks++;
        if ({d0, d1} !== 16'h3CC3) begin
            errors++;
            $display("FAIL read_data got %h exp 3cc3", {d0, d1});
        end
        checks++;
        if (dut.ptr_q !== 4'd1) begin
            errors++;
            $display("FAIL read_ptr got %h exp 1", dut.ptr_q);
        end
        check_writes("read");
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        sda_ever = 1'b0;
        busy_ever = 1'b0;
        bus_start();
        write_byte(8'h86, a0);
        write_byte(8'h01, a1);
        write_byte(8'h55, a1);
        bus_stop();
        checks++;
        if ({a0, sda_ever, busy_ever} !== 3'b000) begin
            errors++;
            $display("FAIL wrong_addr got ack/sda/busy %b exp 000", {a0, sda_ever, busy_ever});
        end
        check_writes("wrong_addr");
    endtask

    task automatic test_bad_ptr();
        logic [2:0] a;
        logic       r;
        logic [7:0] d;
        bus_start();
        write_byte(8'h84, a[2]);
        write_byte(8'h10, a[1]);
        write_byte(8'h77, a[0]);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_ptr_busy got %b exp 0", busy);
        end
        bus_stop();
        checks++;
        if (a !== 3'b100) begin
            errors++;
            $display("FAIL bad_ptr_acks got %b exp 100", a);
        end
        check_writes("bad_ptr");
        bus_start();
        write_byte(8'h85, r);
        read_byte(1'b0, d);
        bus_stop();
        checks++;
        if ({r, d} !== 9'h199) begin
            errors++;
            $display("FAIL bad_ptr_read got %h exp 199", {r, d});
        end
    endtask

    task automatic test_partial_stop();
        logic [1:0] a;
        logic       s;
        bus_start();
        write_byte(8'h84, a[1]);
        write_byte(8'h06, a[0]);
        for (int i = 0; i < 5; i++) send_bit(1'b1, s);
        bus_stop();
        checks++;
        if (a !== 2'b11) begin
            errors++;
            $display("FAIL partial_acks got %b exp 11", a);
        end
        check_writes("partial");
        checks++;
        if (dut.state_q !== ST_IDLE || dut.ptr_q !== 4'd6) begin
            errors++;
            $display("FAIL partial_state got state %0d ptr %h exp state %0d ptr 6", dut.state_q, dut.ptr_q, ST_IDLE);
        end
        host_addr = 4'd6;
        tick(2);
        checks++;
        if (host_data !== 8'h00) begin
            errors++;
            $display("FAIL partial_host got %h exp 00", host_data);
        end
    endtask

`ifdef I2C_TGT_STRETCH_EN
    task automatic test_stretch();
        logic [3:0] a;
        wr_ready = 1'b0;
        stretch_held = 0;
        exp_q.push_back({4'd8, 8'h11});
        exp_q.push_back({4'd9, 8'h22});
        bus_start();
        write_byte(8'h84, a[3]);
        write_byte(8'h08, a[2]);
        fork
            begin
                int k = 0;
                @(negedge clk);
                while (scl_oe !== 1'b1 && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                while (scl_oe === 1'b1 && stretch_held < 1000) begin
                    stretch_held++;
                    if (stretch_held == 50) wr_ready = 1'b1;
                    @(negedge clk);
                end
            end
        join_none
        write_byte(8'h11, a[1]);
        write_byte(8'h22, a[0]);
        bus_stop();
        checks++;
        if (stretch_held !== 50) begin
            errors++;
            $display("FAIL stretch_cycles got %0d exp 50", stretch_held);
        end
        checks++;
        if (a !== 4'b1111) begin
            errors++;
            $display("FAIL stretch_acks got %b exp 1111", a);
        end
        check_writes("stretch");
        wr_ready = 1'b1;
    endtask
`endif

    task automatic test_reset_mid();
        logic s;
        logic [7:0] addr_byte = 8'h84;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_byte[i], s);
        tick(3);
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_drive got %b exp 1", sda_oe);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({sda_oe, scl_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got %b exp 000", {sda_oe, scl_oe, busy});
        end
        rst = 1'b0;
        tick(2);
        bus_stop();
        host_addr = 4'd4;
        tick(2);
        checks++;
        if (host_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_regs got %h exp 00", host_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wrap();
        test_wrong_addr();
        test_bad_ptr();
        test_partial_stop();
`ifdef I2C_TGT_STRETCH_EN
        test_stretch();
`else
        checks++;
        if (scl_oe_ever !== 1'b0) begin
            errors++;
            $display("FAIL scl_oe_tied got %b exp 0", scl_oe_ever);
        end
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
